// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/clear bus between the pipeline (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN,
    parameter int unsigned NREGS  = RF_NREGS,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREAD-1:0]             rd_en;
    logic [NREAD-1:0][AW-1:0]     rd_addr;
    logic [NREAD-1:0][XLEN-1:0]   rd_data;
    logic [NWRITE-1:0]            wr_en;
    logic [NWRITE-1:0][AW-1:0]    wr_addr;
    logic [NWRITE-1:0][XLEN-1:0]  wr_data;
    logic                         clear_req;
    logic                         busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clear_req,
        input  rd_data, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clear_req,
        output rd_data, busy
    );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: busy/range/zero masking, optional write bypass, hold on !rd_en.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NWRITE   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              busy,
    input  logic                              rd_en,
    input  logic [$clog2(NREGS)-1:0]          rd_addr,
    input  logic [XLEN-1:0]                   arr_data,
    input  logic [NWRITE-1:0]                 wr_commit,
    input  logic [NWRITE-1:0][$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWRITE-1:0][XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]                   rd_data
);
    localparam int unsigned AW      = $clog2(NREGS);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0] load_c;

    // Later bypass ports override earlier ones; masking rules override everything.
    always_comb begin
        load_c = arr_data;
        if (BYPASS != 0) begin
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (wr_commit[k] && (wr_addr[k] == rd_addr)) begin
                    load_c = wr_data[k];
                end
            end
        end
        if (busy || ({1'b0, rd_addr} >= NREGS_W) ||
            ((ZERO_REG != 0) && (rd_addr == '0))) begin
            load_c = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= load_c;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NREAD x NWRITE register file; storage is reset-free and zeroed by a sweep FSM.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NWRITE   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW        = $clog2(NREGS);
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_e                  state_q, state_nxt;
    logic [AW-1:0]              sweep_idx_q, sweep_idx_nxt;
    logic                       busy_q, busy_nxt;
    logic [NWRITE-1:0]          wr_commit;
    logic [XLEN-1:0]            regs [NREGS];
    logic [NREAD-1:0][XLEN-1:0] rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RF_SWEEP;
            sweep_idx_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_nxt;
            sweep_idx_q <= sweep_idx_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // Sweep one entry per cycle; clear requests are only honoured from idle.
    always_comb begin
        state_nxt     = state_q;
        sweep_idx_nxt = sweep_idx_q;
        busy_nxt      = busy_q;
        case (state_q)
            RF_IDLE: begin
                if (bus.clear_req) begin
                    state_nxt     = RF_SWEEP;
                    sweep_idx_nxt = '0;
                    busy_nxt      = 1'b1;
                end
            end
            RF_SWEEP: begin
                if (sweep_idx_q == LAST_IDX) begin
                    state_nxt     = RF_IDLE;
                    sweep_idx_nxt = '0;
                    busy_nxt      = 1'b0;
                end else begin
                    sweep_idx_nxt = sweep_idx_q + AW'(1);
                end
            end
            default: begin
                state_nxt     = RF_SWEEP;
                sweep_idx_nxt = '0;
                busy_nxt      = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_commit = '0;
        for (int unsigned k = 0; k < NWRITE; k++) begin
            wr_commit[k] = bus.wr_en[k] && !busy_q &&
                           ({1'b0, bus.wr_addr[k]} < NREGS_W) &&
                           !((ZERO_REG != 0) && (bus.wr_addr[k] == '0));
        end
    end

    // No reset on the array; the highest committing port is applied last and wins.
    always_ff @(posedge clk) begin
        if (state_q == RF_SWEEP) begin
            regs[sweep_idx_q] <= '0;
        end else begin
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (wr_commit[k]) begin
                    regs[bus.wr_addr[k]] <= bus.wr_data[k];
                end
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .clk       (clk),
            .rst       (rst),
            .busy      (busy_q),
            .rd_en     (bus.rd_en[i]),
            .rd_addr   (bus.rd_addr[i]),
            .arr_data  (regs[bus.rd_addr[i]]),
            .wr_commit (wr_commit),
            .wr_addr   (bus.wr_addr),
            .wr_data   (bus.wr_data),
            .rd_data   (rd_q[i])
        );
    end

    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypass, bypass-off and 24-entry instances side by side.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    logic rst_c;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) ifa ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) ifb ();
    regfile_mp_if #(.XLEN(32), .NREGS(24), .NREAD(2), .NWRITE(2)) ifc ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    regfile_mp #(.XLEN(32), .NREGS(24), .NREAD(2), .NWRITE(2), .ZERO_REG(1), .BYPASS(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ifa.rd_en = '0; ifa.wr_en = '0; ifa.clear_req = 1'b0;
        ifb.rd_en = '0; ifb.wr_en = '0; ifb.clear_req = 1'b0;
        ifc.rd_en = '0; ifc.wr_en = '0; ifc.clear_req = 1'b0;
    endtask

    task automatic test_reset();
        int ca = 0, cb = 0, cc = 0;
        logic [31:0] e;
        rst = 1'b1; rst_c = 1'b1;
        tick(); tick();
        n_total++;
        if (ifa.busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", ifa.busy);
        else n_pass++;
        n_total++;
        if (ifa.rd_data !== 64'h0) $display("FAIL reset_rd_data: got %h expected 0", ifa.rd_data);
        else n_pass++;
        ifa.rd_en[0] = 1'b1; ifa.rd_addr[0] = 5'd5; exp_q.push_back(32'h0);
        rst = 1'b0; rst_c = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (cyc == 1) begin
                e = exp_q.pop_front(); n_total++;
                if (ifa.rd_data[0] !== e) $display("FAIL busy_read_r5: got %h expected %h", ifa.rd_data[0], e);
                else n_pass++;
                ifa.rd_en = '0;
            end
            if (ca == 0 && ifa.busy === 1'b0) ca = cyc;
            if (cb == 0 && ifb.busy === 1'b0) cb = cyc;
            if (cc == 0 && ifc.busy === 1'b0) cc = cyc;
            if (ca != 0 && cb != 0 && cc != 0) break;
        end
        n_total++;
        if (ca != 32) $display("FAIL reset_sweep_len_a: got %0d expected 32", ca); else n_pass++;
        n_total++;
        if (cb != 32) $display("FAIL reset_sweep_len_b: got %0d expected 32", cb); else n_pass++;
        n_total++;
        if (cc != 24) $display("FAIL reset_sweep_len_c: got %0d expected 24", cc); else n_pass++;
    endtask

    task automatic test_basic_rw();
        logic [31:0] e;
        ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd3; ifa.wr_data[0] = 32'hDEADBEEF;
        tick();
        ifa.wr_en = '0; ifa.rd_en = 2'b01; ifa.rd_addr[0] = 5'd3; exp_q.push_back(32'hDEADBEEF);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[0] !== e) $display("FAIL basic_r3: got %h expected %h", ifa.rd_data[0], e);
        else n_pass++;
        ifa.rd_en = '0; ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd0; ifa.wr_data[0] = 32'h1234;
        tick();
        ifa.wr_en = '0; ifa.rd_en = 2'b01; ifa.rd_addr[0] = 5'd0; exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[0] !== e) $display("FAIL basic_r0: got %h expected %h", ifa.rd_data[0], e);
        else n_pass++;
        ifa.rd_en = '0;
    endtask

    task automatic test_bypass_conflict();
        logic [31:0] e;
        ifa.wr_en = 2'b11; ifa.wr_addr[0] = 5'd7; ifa.wr_addr[1] = 5'd7;
        ifa.wr_data[0] = 32'h11; ifa.wr_data[1] = 32'h22;
        ifa.rd_en = 2'b01; ifa.rd_addr[0] = 5'd7;
        ifb.wr_en = 2'b11; ifb.wr_addr[0] = 5'd7; ifb.wr_addr[1] = 5'd7;
        ifb.wr_data[0] = 32'h11; ifb.wr_data[1] = 32'h22;
        ifb.rd_en = 2'b01; ifb.rd_addr[0] = 5'd7;
        exp_q.push_back(32'h22); exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[0] !== e) $display("FAIL bypass_conflict_a: got %h expected %h", ifa.rd_data[0], e);
        else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (ifb.rd_data[0] !== e) $display("FAIL nobypass_old_b: got %h expected %h", ifb.rd_data[0], e);
        else n_pass++;
        ifa.wr_en = '0; ifb.wr_en = '0;
        exp_q.push_back(32'h22); exp_q.push_back(32'h22);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[0] !== e) $display("FAIL conflict_stored_a: got %h expected %h", ifa.rd_data[0], e);
        else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (ifb.rd_data[0] !== e) $display("FAIL conflict_stored_b: got %h expected %h", ifb.rd_data[0], e);
        else n_pass++;
        ifa.rd_en = '0; ifb.rd_en = '0;
    endtask

    task automatic test_hold();
        logic [31:0] e;
        ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'd9; ifa.wr_data[0] = 32'hA5A5A5A5;
        ifa.rd_en = 2'b10; ifa.rd_addr[1] = 5'd9; exp_q.push_back(32'hA5A5A5A5);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[1] !== e) $display("FAIL hold_load: got %h expected %h", ifa.rd_data[1], e);
        else n_pass++;
        ifa.rd_en = '0; ifa.wr_data[0] = 32'h5; exp_q.push_back(32'hA5A5A5A5);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[1] !== e) $display("FAIL hold_during_write: got %h expected %h", ifa.rd_data[1], e);
        else n_pass++;
        ifa.wr_en = '0; exp_q.push_back(32'hA5A5A5A5);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[1] !== e) $display("FAIL hold_idle: got %h expected %h", ifa.rd_data[1], e);
        else n_pass++;
        ifa.rd_en = 2'b10; exp_q.push_back(32'h5);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[1] !== e) $display("FAIL hold_reload: got %h expected %h", ifa.rd_data[1], e);
        else n_pass++;
        ifa.rd_en = '0;
    endtask

    task automatic test_clear();
        logic [31:0] e;
        int cnt = 0;
        for (int i = 1; i < 32; i++) begin
            ifa.wr_en = 2'b01; ifa.wr_addr[0] = 5'(i); ifa.wr_data[0] = 32'h100 + 32'(i);
            tick();
        end
        ifa.wr_en = '0; ifa.rd_en = 2'b01; ifa.rd_addr[0] = 5'd31; exp_q.push_back(32'h11F);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifa.rd_data[0] !== e) $display("FAIL fill_r31: got %h expected %h", ifa.rd_data[0], e);
        else n_pass++;
        ifa.rd_en = '0; ifa.clear_req = 1'b1;
        tick();
        ifa.clear_req = 1'b0;
        n_total++;
        if (ifa.busy !== 1'b1) $display("FAIL clear_busy_rise: got %b expected 1", ifa.busy);
        else n_pass++;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            ifa.wr_en = (cyc == 10) ? 2'b01 : 2'b00;
            ifa.wr_addr[0] = 5'd3; ifa.wr_data[0] = 32'hBAD;
            ifa.clear_req = (cyc == 12);
            tick();
            if (ifa.busy === 1'b0) begin
                cnt = cyc;
                break;
            end
        end
        ifa.wr_en = '0; ifa.clear_req = 1'b0;
        n_total++;
        if (cnt != 32) $display("FAIL clear_busy_len: got %0d expected 32", cnt); else n_pass++;
        for (int i = 0; i < 32; i += 2) begin
            ifa.rd_en = 2'b11; ifa.rd_addr[0] = 5'(i); ifa.rd_addr[1] = 5'(i + 1);
            exp_q.push_back(32'h0); exp_q.push_back(32'h0);
            tick();
            e = exp_q.pop_front(); n_total++;
            if (ifa.rd_data[0] !== e) $display("FAIL clear_read r%0d: got %h expected %h", i, ifa.rd_data[0], e);
            else n_pass++;
            e = exp_q.pop_front(); n_total++;
            if (ifa.rd_data[1] !== e) $display("FAIL clear_read r%0d: got %h expected %h", i + 1, ifa.rd_data[1], e);
            else n_pass++;
        end
        ifa.rd_en = '0;
    endtask

    task automatic test_sweep_reset();
        logic [31:0] e;
        int cnt = 0;
        ifc.wr_en = 2'b01; ifc.wr_addr[0] = 5'd5; ifc.wr_data[0] = 32'h77;
        ifc.rd_en = 2'b01; ifc.rd_addr[0] = 5'd5; exp_q.push_back(32'h77);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifc.rd_data[0] !== e) $display("FAIL c_r5_write: got %h expected %h", ifc.rd_data[0], e);
        else n_pass++;
        ifc.wr_en = '0; ifc.rd_en = '0; ifc.clear_req = 1'b1;
        tick();
        ifc.clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_c = 1'b1;
        #1;
        n_total++;
        if (ifc.rd_data[0] !== 32'h0) $display("FAIL c_reset_rd_data: got %h expected 0", ifc.rd_data[0]);
        else n_pass++;
        tick(); tick();
        rst_c = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (ifc.busy === 1'b0) begin
                cnt = cyc;
                break;
            end
        end
        n_total++;
        if (cnt != 24) $display("FAIL c_busy_len: got %0d expected 24", cnt); else n_pass++;
        ifc.wr_en = 2'b01; ifc.wr_addr[0] = 5'd23; ifc.wr_data[0] = 32'h2323;
        tick();
        ifc.wr_en = '0; ifc.rd_en = 2'b01; ifc.rd_addr[0] = 5'd23; exp_q.push_back(32'h2323);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifc.rd_data[0] !== e) $display("FAIL c_r23: got %h expected %h", ifc.rd_data[0], e);
        else n_pass++;
        ifc.wr_en = 2'b01; ifc.wr_addr[0] = 5'd30; ifc.wr_data[0] = 32'hCAFE;
        ifc.rd_addr[0] = 5'd30; exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifc.rd_data[0] !== e) $display("FAIL c_addr30_bypass: got %h expected %h", ifc.rd_data[0], e);
        else n_pass++;
        ifc.wr_en = '0; ifc.rd_addr[0] = 5'd23; exp_q.push_back(32'h2323);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifc.rd_data[0] !== e) $display("FAIL c_r23_again: got %h expected %h", ifc.rd_data[0], e);
        else n_pass++;
        ifc.rd_addr[0] = 5'd30; exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifc.rd_data[0] !== e) $display("FAIL c_addr30_read: got %h expected %h", ifc.rd_data[0], e);
        else n_pass++;
        ifc.rd_addr[0] = 5'd23;
        tick();
        ifc.rd_addr[0] = 5'd5; exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front(); n_total++;
        if (ifc.rd_data[0] !== e) $display("FAIL c_r5_cleared: got %h expected %h", ifc.rd_data[0], e);
        else n_pass++;
        ifc.rd_en = '0;
    endtask

    initial begin
        rst = 1'b1; rst_c = 1'b1;
        quiet();
        ifa.rd_addr = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifb.rd_addr = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifc.rd_addr = '0; ifc.wr_addr = '0; ifc.wr_data = '0;
        test_reset();
        test_basic_rw();
        test_bypass_conflict();
        test_hold();
        test_clear();
        test_sweep_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the rv5stage core and any dual-issue successor. It generalises the 2R1W regfile with the following:
- Configurable width, depth, read-port count and write-port count.
- Optional hardwired zero register.
- Optional write-to-read bypass.
- Per-port read enable (hold).
- A sequential clear sweep, so the storage array itself carries no reset and maps to LUTRAM/BRAM.

It sits between decode (reads) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (>=2)
NREAD, 2, number of read ports
NWRITE, 1, number of write ports
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
(derived localparam AW = $clog2(NREGS))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rd_en  in  NREAD  per-port read enable; low = hold rd_data
rd_addr  in  NREAD x AW  read addresses
rd_data  out  NREAD x XLEN  registered read data
wr_en  in  NWRITE  per-port write enable
wr_addr  in  NWRITE x AW  write addresses
wr_data  in  NWRITE x XLEN  write data
clear_req  in  1  one-cycle pulse: re-zero the whole array
busy  out  1  high while a clear sweep is running

Behaviour:
- Reset (async, active-high):
  - all rd_data = 0, busy = 1, state = SWEEP, sweep_idx = 0.
  - The array has no reset; it is cleared by the sweep.
- State machine: IDLE, SWEEP.
  - SWEEP: each cycle writes 0 to regs[sweep_idx], then sweep_idx increments.
  - When sweep_idx == NREGS-1, that final zero is written and the state goes to IDLE on the next edge. busy is low from that edge onward.
  - A sweep takes exactly NREGS cycles after rst deasserts.
  - IDLE: clear_req = 1 moves to SWEEP at the next edge with sweep_idx = 0. busy rises on that edge.
  - clear_req during SWEEP is ignored; the sweep does not restart.
  - rst asserted mid-sweep restarts the sweep from index 0.
- Writes:
  - Write port k commits on the edge where wr_en[k]=1, busy=0, and wr_addr[k] < NREGS.
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Writes while busy=1 are dropped silently; the pipeline must stall on busy.
  - Multiple ports writing the same address in one cycle: the highest port index wins.
- Reads:
  - Latency is 1 cycle. With rd_en[i]=1, rd_data[i] is loaded on the next edge. With rd_en[i]=0, rd_data[i] holds its value.
  - The loaded value is determined by the first matching rule, in this priority order:
    1. busy=1 → 0.
    2. addr >= NREGS → 0.
    3. ZERO_REG=1 and addr == 0 → 0.
    4. BYPASS=1 and some committing write port matches addr → wr_data of the highest matching port index.
    5. Otherwise → the current array contents.
  - BYPASS=0: a same-cycle read of a written address returns the old value.
- All read ports are independent; any addresses may coincide.

Decomposition:
- Package regfile_pkg holds:
  - state enum rf_state_e {RF_IDLE, RF_SWEEP};
  - default constants RF_XLEN=32, RF_NREGS=32.
- Sub-module rf_read_port: one per read port via generate. It contains the zero/range/bypass priority mux and the hold register.
- Write arbitration and the sweep FSM stay in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles, release → busy=1 for exactly 32 cycles, then 0. During that window, reading r5 with rd_en=1 → rd_data=0.
- Basic write/read: write r3=0xDEADBEEF, next cycle read r3 on port 0 → rd_data[0]=0xDEADBEEF one cycle later. Write r0=0x1234 then read r0 → 0.
- Bypass and conflict (NWRITE=2): in the same cycle, port0 writes r7=0x11 and port1 writes r7=0x22, with read r7 → rd_data=0x22. Next cycle read r7 → 0x22. With BYPASS=0, the same-cycle read returns the old value 0.
- Hold: load rd_data[1]=0xA5A5A5A5 from r9, then drop rd_en[1] and write r9=0x5 → rd_data[1] stays 0xA5A5A5A5 until rd_en[1] reasserts, then reads 0x5.
- Clear sweep: fill r1..r31 with nonzero values, pulse clear_req → busy high 32 cycles. A write during busy is dropped. Afterwards all registers read 0. A second clear_req mid-sweep does not extend busy.
- Reset mid-sweep / odd depth (NREGS=24): assert rst at sweep index 10 → sweep restarts and busy lasts 24 cycles after release. Read/write of address 30 → read 0, write dropped.
